// File: rtl/adder_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : adder_pkg
// Shared types and the gated 4-bit add used by the adder-family blocks.
// Revision: 1.0
// ============================================================================
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam int OPA_W = 4;
  localparam int RES_W = 5;

  // Only b values 3 and 5 let the sum through; anything else reads as zero.
  function automatic logic gate_pass(input logic [OPA_W-1:0] b);
    return (b == 4'd3) || (b == 4'd5);
  endfunction

  function automatic logic [RES_W-1:0] adder_calc(input logic [OPA_W-1:0] a,
                                                  input logic [OPA_W-1:0] b);
    logic [RES_W-1:0] sum;
    if (a >= 4'd1 && a <= 4'd3) sum = {a, 1'b0} + {1'b0, b};
    else                        sum = {1'b0, a} + {1'b0, b};
    return gate_pass(b) ? sum : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : adder_rr_sched_if
// Request and response handshake bundle between requesters and the scheduler.
// Revision: 1.0
// ============================================================================
interface adder_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import adder_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*OPA_W-1:0] req_a;
  logic [NUM_REQ*OPA_W-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [RES_W-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface
`default_nettype wire

// File: rtl/adder_rr_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [ID_W-1:0]    ptr,
  output logic      [NUM_REQ-1:0] gnt,
  output logic      [ID_W-1:0]    gnt_idx
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_sum   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // One extra bit keeps ptr+off exact before the modulo fold.
      w_sum = {1'b0, ptr} + (ID_W+1)'(off);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : adder_rr_sched
// Round-robin scheduler sharing one registered gated adder; optional stats
// counters built when ADDER_RR_SCHED_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module adder_rr_sched
  import adder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  adder_rr_sched_if.slave       bus,
  output logic                  busy
`ifdef ADDER_RR_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  sched_state_e     state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [ID_W-1:0]  gnt_q;
  logic [OPA_W-1:0] a_q;
  logic [OPA_W-1:0] b_q;
  logic             rsp_valid_q;
  logic [RES_W-1:0] rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_take;
  logic               w_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // rst in the term keeps req_ready low while reset is held, not just after it.
  assign w_take   = rst && (state_q == IDLE) && (|bus.req_valid);
  assign w_hs     = (state_q == RESP) && bus.rsp_ready;
  assign rr_ptr_d = (gnt_q == ID_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;

  assign bus.req_ready = w_take ? w_gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_take) begin
            a_q     <= bus.req_a[int'(w_gnt_idx)*OPA_W +: OPA_W];
            b_q     <= bus.req_b[int'(w_gnt_idx)*OPA_W +: OPA_W];
            gnt_q   <= w_gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= adder_calc(a_q, b_q);
          rsp_id_q    <= gnt_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ADDER_RR_SCHED_STATS_EN
  logic [15:0] drop_cnt_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else if (w_take && w_gnt[gi] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end

  // b_q is still the operand of the response being handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else if (w_hs && !gate_pass(b_q) && drop_cnt_q != 16'hFFFF)
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire
